jt900h_fetch: RTL



---
 rtl/jt900h_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jt900h_fetch.sv
// JT900H instruction prefetch queue: fills an 8-byte circular buffer from
// aligned 16-bit bus reads and presents the head byte plus four lookahead bytes.
module jt900h_fetch #(
  parameter int unsigned QW = 8
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        ld_pc,
  input  logic [23:0] pc_nx,
  input  logic        inc_pc,
  input  logic [1:0]  fetch_sel,
  output logic [7:0]  md,
  output logic [31:0] op,
  output logic [23:0] pc,
  output logic        mem_busy,
  output logic        bus_rd,
  output logic [23:0] bus_addr,
  input  logic [15:0] bus_din,
  input  logic        bus_ok
);

  localparam int unsigned AW = $clog2(QW);
  localparam int unsigned CW = AW + 1;

  // OFF: no PC loaded yet; BUSY: read outstanding; DROP: outstanding read to discard
  typedef enum logic [1:0] {OFF, IDLE, BUSY, DROP} state_t;

  state_t          state;
  logic [7:0]      q [QW];
  logic [AW-1:0]   rp, wp;
  logic [CW-1:0]   cnt, need, put, eat;
  logic [23:0]     fa;
  logic            wr, take;

  always_comb begin
    case (fetch_sel)
      2'd1:    need = CW'(1);
      2'd2:    need = CW'(2);
      2'd3:    need = CW'(4);
      default: need = '0;
    endcase
    mem_busy = inc_pc && (fetch_sel != 2'd0) && (cnt < need);
    take     = inc_pc && (fetch_sel != 2'd0) && !ld_pc && (cnt >= need);
    eat      = take ? need : '0;
    wr       = bus_ok && (state == BUSY) && !ld_pc;
    if (!wr)
      put = '0;
    else if (fa[0])
      put = CW'(1);
    else
      put = CW'(2);
    md = q[rp];
    op = {q[rp + AW'(4)], q[rp + AW'(3)], q[rp + AW'(2)], q[rp + AW'(1)]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      bus_rd   <= 1'b0;
      bus_addr <= '0;
      pc       <= '0;
      fa       <= '0;
      rp       <= '0;
      wp       <= '0;
      cnt      <= '0;
      for (int unsigned i = 0; i < QW; i++) q[i] <= '0;
    end else if (cen) begin
      if (ld_pc) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
        pc  <= pc_nx;
        fa  <= pc_nx;
        case (state)
          BUSY, DROP: begin
            // an in-flight read must still complete on the bus, so keep
            // bus_rd up and discard its data when it arrives
            if (bus_ok) begin
              state  <= IDLE;
              bus_rd <= 1'b0;
            end else begin
              state  <= DROP;
            end
          end
          default: begin
            state    <= BUSY;
            bus_rd   <= 1'b1;
            bus_addr <= {pc_nx[23:1], 1'b0};
          end
        endcase
      end else begin
        if (wr) begin
          if (fa[0]) begin
            q[wp] <= bus_din[15:8];
            wp    <= wp + AW'(1);
            fa    <= fa + 24'd1;
          end else begin
            q[wp]          <= bus_din[7:0];
            q[wp + AW'(1)] <= bus_din[15:8];
            wp             <= wp + AW'(2);
            fa             <= fa + 24'd2;
          end
        end
        if (take) begin
          rp <= rp + need[AW-1:0];
          pc <= pc + 24'(need);
        end
        cnt <= cnt + put - eat;
        case (state)
          IDLE: begin
            if (cnt <= CW'(QW - 2)) begin
              state    <= BUSY;
              bus_rd   <= 1'b1;
              bus_addr <= {fa[23:1], 1'b0};
            end
          end
          BUSY, DROP: begin
            if (bus_ok) begin
              state  <= IDLE;
              bus_rd <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
